// File: rtl/spi_master_ctrl.sv
// SPI master engine: single/dual/quad lanes, CPOL/CPHA modes 0-3, MSB/LSB-first words.
// Latency start->done = 1 + CS_SETUP + 2N*CLK_DIV + CS_HOLD; start is ignored while ready=0 (no queuing).
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds the driven mosi lanes back as miso.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_SETUP   = 1,
    parameter int CS_HOLD    = 1,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [1:0]            lane_mode,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  done,
    output logic                  sclk,
    output logic                  cs,
    output logic [3:0]            mosi,
    input  logic [3:0]            miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic                  loopback
`endif
);

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state;
    logic [15:0]           cnt;
    logic [15:0]           div_cnt;
    logic [6:0]            edge_cnt;
    logic [6:0]            edges_total;
    logic                  cfg_valid;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [2:0]            lanes_q;
    logic [DATA_WIDTH-1:0] tx_sreg;
    logic [DATA_WIDTH-1:0] rx_sreg;
    logic [3:0]            rx_src;
    logic                  edge_now;
    logic                  edge_lead;
    logic                  do_sample;
    logic                  do_launch;

    function automatic logic [2:0] lanes_of(input logic [1:0] m);
        case (m)
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Highest lane always carries the most significant bit of the beat.
    function automatic logic [3:0] beat_of(input logic [DATA_WIDTH-1:0] w, input logic [2:0] l,
                                           input logic lsb);
        logic [3:0] b;
        b = '0;
        case (l)
            3'd2:    b[1:0] = lsb ? w[1:0] : w[DATA_WIDTH-1 -: 2];
            3'd4:    b      = lsb ? w[3:0] : w[DATA_WIDTH-1 -: 4];
            default: b[0]   = lsb ? w[0]   : w[DATA_WIDTH-1];
        endcase
        return b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [2:0] l, input logic lsb);
        case (l)
            3'd2:    return lsb ? (w >> 2) : (w << 2);
            3'd4:    return lsb ? (w >> 4) : (w << 4);
            default: return lsb ? (w >> 1) : (w << 1);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rx_in(input logic [DATA_WIDTH-1:0] r,
                                                    input logic [3:0] b, input logic [2:0] l,
                                                    input logic lsb);
        case (l)
            3'd2:    return lsb ? {b[1:0], r[DATA_WIDTH-1:2]} : {r[DATA_WIDTH-3:0], b[1:0]};
            3'd4:    return lsb ? {b, r[DATA_WIDTH-1:4]}      : {r[DATA_WIDTH-5:0], b};
            default: return lsb ? {b[0], r[DATA_WIDTH-1:1]}   : {r[DATA_WIDTH-2:0], b[0]};
        endcase
    endfunction

    always_comb begin
        case (lanes_q)
            3'd2:    edges_total = 7'(DATA_WIDTH);
            3'd4:    edges_total = 7'(DATA_WIDTH / 2);
            default: edges_total = 7'(2 * DATA_WIDTH);
        endcase
    end

    always_comb begin
        rx_src = miso;
`ifdef SPI_MASTER_LOOPBACK_EN
        if (loopback) begin
            rx_src = mosi;
        end
`endif
    end

    // The first sclk edge fires as SETUP ends, so cs-to-edge spacing is exactly CS_SETUP.
    always_comb begin
        edge_now  = (state == SETUP && cnt == SETUP_LAST) ||
                    (state == SHIFT && div_cnt == DIV_LAST && edge_cnt != edges_total);
        edge_lead = ~edge_cnt[0];
        do_sample = cpha_q ? ~edge_lead : edge_lead;
        do_launch = cpha_q ? edge_lead : (~edge_lead && (edge_cnt + 7'd1 != edges_total));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= '0;
            rx_data   <= '0;
            done      <= 1'b0;
            ready     <= 1'b1;
            cnt       <= '0;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            cfg_valid <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            lanes_q   <= 3'd1;
            tx_sreg   <= '0;
            rx_sreg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cfg_valid ? cpol_q : cpol;
                    if (start) begin
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        lsb_q     <= lsb_first;
                        lanes_q   <= lanes_of(lane_mode);
                        cfg_valid <= 1'b1;
                        ready     <= 1'b0;
                        cs        <= 1'b0;
                        sclk      <= cpol;
                        cnt       <= '0;
                        edge_cnt  <= '0;
                        rx_sreg   <= '0;
                        state     <= SETUP;
                        if (!cpha) begin
                            mosi    <= beat_of(tx_data, lanes_of(lane_mode), lsb_first);
                            tx_sreg <= shift_out(tx_data, lanes_of(lane_mode), lsb_first);
                        end else begin
                            mosi    <= '0;
                            tx_sreg <= tx_data;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (edge_cnt == edges_total) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= GAP;
                        cs      <= 1'b1;
                        mosi    <= '0;
                        done    <= 1'b1;
                        rx_data <= rx_sreg;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (edge_now) begin
                sclk     <= ~sclk;
                edge_cnt <= edge_cnt + 7'd1;
                if (do_sample) begin
                    rx_sreg <= rx_in(rx_sreg, rx_src, lanes_q, lsb_q);
                end
                if (do_launch) begin
                    mosi    <= beat_of(tx_sreg, lanes_q, lsb_q);
                    tx_sreg <= shift_out(tx_sreg, lanes_q, lsb_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: timeline model checked every cycle, reactive SPI slave, literal checks.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback path.
module tb_spi_master_ctrl;

    localparam int DW = 8;
    localparam int P_DIV = 2;
    localparam int P_SETUP = 1;
    localparam int P_HOLD = 1;
    localparam int P_GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic [7:0] tx_data = 8'h00;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [1:0] lane_mode = 2'd0;
    logic       lsb_first = 1'b0;
    logic [7:0] rx_data;
    logic       done;
    logic       sclk;
    logic       cs;
    logic [3:0] mosi;
    logic [3:0] miso = 4'h0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    spi_master_ctrl #(
        .DATA_WIDTH(DW), .CLK_DIV(P_DIV), .CS_SETUP(P_SETUP), .CS_HOLD(P_HOLD), .CS_GAP(P_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .tx_data(tx_data), .cpol(cpol),
        .cpha(cpha), .lane_mode(lane_mode), .lsb_first(lsb_first), .rx_data(rx_data),
        .done(done), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cycle=%0d", nm, got, exp, cyc);
        end
    endtask

    function automatic int lanes(input logic [1:0] m);
        return (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    endfunction

    // Beat j of a word: MSB-first takes the top L bits first, LSB-first the bottom L bits first.
    function automatic logic [3:0] beat_at(input logic [7:0] w, input int j, input int l, input bit lsb);
        int sh;
        logic [31:0] ww;
        ww = 32'(w);
        sh = lsb ? l * j : l * (DW / l - 1 - j);
        return 4'((ww >> sh) & 32'((1 << l) - 1));
    endfunction

    logic [3:0] slv [0:31];
    logic [3:0] mo_beats [0:31];
    int s_idx = 0, s_pulses = 0, s_edges = 0, s_mcnt = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0;

    function automatic logic [3:0] slv_drive(input int i);
        logic [3:0] m;
        m = 4'((1 << lanes(lane_mode)) - 1);
        return (slv[i] & m) | (4'hA & ~m);
    endfunction

    // Slave: presents miso beats on its launch edges, records mosi on its sample edges.
    always @(negedge clk) begin
        bit lead;
        if (cs === 1'b0) begin
            if (p_cs === 1'b1) begin
                s_pulses = 0; s_edges = 0; s_mcnt = 0; s_idx = 0;
                if (!cpha) begin
                    miso = slv_drive(0);
                    s_idx = 1;
                end
            end else if (sclk !== p_sclk) begin
                lead = (sclk != cpol);
                s_edges++;
                if (lead) s_pulses++;
                if (lead != cpha && s_mcnt < 32) begin
                    mo_beats[s_mcnt] = mosi;
                    s_mcnt++;
                end
                if (lead == cpha && s_idx < 32) begin
                    miso = slv_drive(s_idx);
                    s_idx++;
                end
            end
        end
        p_cs = cs;
        p_sclk = sclk;
    end

    bit m_act = 0, m_have_cfg = 0, m_cfg_cpol = 0, last_cpol_in = 0, chk_en = 0;
    bit m_cpol, m_cpha, m_lsb;
    int m_start, m_l, m_n, m_tsh0, m_thold0, m_tdone, m_tidle;
    logic [7:0] m_tx, m_rx = 8'h00, m_rx_exp;
    int n_done = 0, done_cyc = 0, cs_hi_run = 0, last_gap = 0;

    always @(negedge clk) begin
        int t, h, j;
        logic es;
        cyc++;
        if (cs === 1'b1) cs_hi_run++;
        else begin
            if (cs_hi_run > 0) last_gap = cs_hi_run;
            cs_hi_run = 0;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (chk_en) begin
            if (m_act && (cyc - m_start) >= m_tidle) m_act = 0;
            if (!m_act) begin
                chk("cs_idle", 32'(cs), 1);
                chk("ready_idle", 32'(ready), 1);
                chk("done_idle", 32'(done), 0);
                chk("mosi_idle", 32'(mosi), 0);
                chk("sclk_idle", 32'(sclk), 32'(m_have_cfg ? m_cfg_cpol : last_cpol_in));
            end else begin
                t = cyc - m_start;
                h = (t - m_tsh0) / P_DIV;
                chk("ready_busy", 32'(ready), 0);
                chk("cs_busy", 32'(cs), (t < m_tdone) ? 0 : 1);
                chk("done_busy", 32'(done), (t == m_tdone) ? 1 : 0);
                if (t == m_tdone) m_rx = m_rx_exp;
                es = (t >= m_tsh0 && t < m_thold0) ? (m_cpol ^ (h % 2 == 0)) : m_cpol;
                chk("sclk_busy", 32'(sclk), 32'(es));
                if (t >= m_tdone) chk("mosi_gap", 32'(mosi), 0);
                else if (t >= m_tsh0 && t < m_thold0) begin
                    j = m_cpha ? h / 2 : (((h + 1) / 2 < m_n) ? (h + 1) / 2 : m_n - 1);
                    chk("mosi_shift", 32'(mosi), 32'(beat_at(m_tx, j, m_l, m_lsb)));
                end else if (t < m_tsh0 && !m_cpha)
                    chk("mosi_setup", 32'(mosi), 32'(beat_at(m_tx, 0, m_l, m_lsb)));
            end
            chk("rx_data", 32'(rx_data), 32'(m_rx));
        end
        if (rst) begin
            m_act = 0; m_have_cfg = 0; m_rx = 8'h00; last_cpol_in = 0; chk_en = 1;
        end else if (!m_act && start) begin
            m_act = 1; m_start = cyc; m_have_cfg = 1; m_cfg_cpol = cpol;
            m_cpol = cpol; m_cpha = cpha; m_lsb = lsb_first; m_tx = tx_data;
            m_l = lanes(lane_mode); m_n = DW / m_l;
            m_tsh0 = 1 + P_SETUP;
            m_thold0 = m_tsh0 + 2 * m_n * P_DIV;
            m_tdone = m_thold0 + P_HOLD;
            m_tidle = m_tdone + P_GAP;
            m_rx_exp = 8'h00;
            for (int k = 0; k < m_n; k++) begin
                m_rx_exp = m_rx_exp | 8'((32'(slv[k]) & 32'((1 << m_l) - 1)) <<
                           (m_lsb ? m_l * k : m_l * (m_n - 1 - k)));
            end
`ifdef SPI_MASTER_LOOPBACK_EN
            if (loopback) m_rx_exp = tx_data;
`endif
        end else if (!m_act && !m_have_cfg) begin
            last_cpol_in = cpol;
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_slave(input logic [7:0] w, input logic [1:0] lm, input bit lsb);
        for (int k = 0; k < 32; k++) slv[k] = 4'h0;
        for (int k = 0; k < DW / lanes(lm); k++) slv[k] = beat_at(w, k, lanes(lm), lsb);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (ready !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (n_done == base && k < 400) begin
            tick(1);
            k++;
        end
        chk("done_seen", 32'(n_done - base), 1);
    endtask

    task automatic kick(input logic [7:0] tx, input bit pol, input bit pha, input logic [1:0] lm,
                        input bit lsb, input logic [7:0] sw);
        wait_ready();
        load_slave(sw, lm, lsb);
        tx_data = tx; cpol = pol; cpha = pha; lane_mode = lm; lsb_first = lsb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input bit pol, input bit pha, input logic [1:0] lm,
                        input bit lsb, input logic [7:0] sw);
        int base;
        base = n_done;
        kick(tx, pol, pha, lm, lsb, sw);
        wait_done(base);
    endtask

    initial begin
        logic [7:0] acc;
        int base;
        tick(3);
        rst = 1'b0;
        chk("rst_cs", 32'(cs), 1);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_rx", 32'(rx_data), 0);
        tick(2);

        // Mode 0, single lane, MSB first.
        xfer(8'hA5, 0, 0, 2'd0, 0, 8'h3C);
        chk("m0_rx", 32'(rx_data), 32'h3C);
        chk("m0_latency", 32'(done_cyc - m_start), 35);
        chk("m0_pulses", 32'(s_pulses), 8);
        acc = 8'h00;
        for (int k = 0; k < 8; k++) acc = {acc[6:0], mo_beats[k][0]};
        chk("m0_mosi_bits", 32'(acc), 32'hA5);
        tick(4);

        // Mode 3, quad lane.
        xfer(8'h5A, 1, 1, 2'd2, 0, 8'hF0);
        chk("m3_rx", 32'(rx_data), 32'hF0);
        chk("m3_latency", 32'(done_cyc - m_start), 11);
        chk("m3_pulses", 32'(s_pulses), 2);
        chk("m3_beats", 32'({mo_beats[0], mo_beats[1]}), 32'h5A);
        tick(4);
        chk("m3_idle_sclk", 32'(sclk), 1);

        // Dual lane, LSB first.
        xfer(8'hC6, 0, 0, 2'd1, 1, 8'h93);
        chk("dual_rx", 32'(rx_data), 32'h93);
        chk("dual_latency", 32'(done_cyc - m_start), 19);
        chk("dual_pulses", 32'(s_pulses), 4);
        chk("dual_beats", 32'({mo_beats[0][1:0], mo_beats[1][1:0], mo_beats[2][1:0], mo_beats[3][1:0]}),
            32'b10_01_00_11);
        tick(4);

        // start held high: back-to-back transfers keep a cs-high gap.
        base = n_done;
        wait_ready();
        load_slave(8'h81, 2'd0, 0);
        tx_data = 8'h3E; cpol = 0; cpha = 1; lane_mode = 2'd0; lsb_first = 0;
        start = 1'b1;
        for (int k = 0; k < 200 && n_done < base + 2; k++) tick(1);
        start = 1'b0;
        chk("held_two_done", 32'(n_done - base), 2);
        chk("held_gap_ok", 32'(last_gap >= P_GAP), 1);
        chk("held_rx", 32'(rx_data), 32'h81);
        tick(8);

        // start pulse while busy is ignored.
        base = n_done;
        kick(8'h11, 0, 0, 2'd0, 0, 8'h22);
        tick(10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_ready();
        tick(40);
        chk("busy_start_ignored", 32'(n_done - base), 1);

        // Reset on the third sclk edge.
        base = n_done;
        kick(8'hFF, 0, 0, 2'd0, 0, 8'h00);
        for (int k = 0; k < 100 && s_edges < 3; k++) tick(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_cs", 32'(cs), 1);
        chk("rstmid_sclk", 32'(sclk), 0);
        chk("rstmid_mosi", 32'(mosi), 0);
        chk("rstmid_ready", 32'(ready), 1);
        chk("rstmid_done", 32'(done), 0);
        rst = 1'b0;
        tick(60);
        chk("rstmid_no_done", 32'(n_done - base), 0);

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1;
        xfer(8'h96, 0, 0, 2'd0, 0, 8'h00);
        chk("loopback_rx", 32'(rx_data), 32'h96);
        loopback = 1'b0;
        tick(4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
